// File: rtl/sigma_delta_dac_pkg.sv
// sigma_delta_dac_pkg: shared sample/integrator widths, feedback level and integrator clamp
package sigma_delta_dac_pkg;
   localparam int SAMPLE_W = 24;
   localparam int INT_W = 28;
   localparam logic signed [INT_W-1:0] FB_MAG = 28'sd8388608;
   function automatic logic signed [INT_W-1:0] sat28(input logic signed [INT_W+1:0] v);
      return (v[INT_W+1:INT_W-1] == 3'b000 || v[INT_W+1:INT_W-1] == 3'b111) ? v[INT_W-1:0] :
             v[INT_W+1] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
   endfunction
endpackage

// File: rtl/sigma_delta_dac_modulator.sv
// sigma_delta_dac_modulator: second-order 1-bit loop with saturating integrators
module sigma_delta_dac_modulator
   import sigma_delta_dac_pkg::*;
(
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Tick,
   input  logic [SAMPLE_W-1:0] X,
   input  logic                Mute,
   output logic                Bit
);
   logic signed [INT_W-1:0] r_i1, r_i2, w_x, w_fb, w_i1, w_i2;
   // candidate integrator states from the current input and previous output bit
   always_comb begin
      w_x  = Mute ? '0 : {{(INT_W-SAMPLE_W){X[SAMPLE_W-1]}}, X};
      w_fb = Bit ? FB_MAG : -FB_MAG;
      w_i1 = sat28({{2{r_i1[INT_W-1]}}, r_i1} + {{2{w_x[INT_W-1]}}, w_x} - {{2{w_fb[INT_W-1]}}, w_fb});
      w_i2 = sat28({{2{r_i2[INT_W-1]}}, r_i2} + {{2{w_i1[INT_W-1]}}, w_i1} - {{2{w_fb[INT_W-1]}}, w_fb});
   end
   // integrators and output bit advance once per bit tick
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_i1 <= '0;
         r_i2 <= '0;
         Bit  <= 1'b0;
      end else if (Tick) begin
         r_i1 <= w_i1;
         r_i2 <= w_i2;
         Bit  <= ~w_i2[INT_W-1];
      end
   end
endmodule

// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: buffered sample input, linear interpolation and bit clocking around the modulator
module sigma_delta_dac
   import sigma_delta_dac_pkg::*;
#(
   parameter int CLK_DIV_LOG2 = 3,
   parameter int OSR_LOG2     = 6
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [SAMPLE_W-1:0] Input,
   input  logic                Input_Valid,
   output logic                Input_Ready,
   input  logic                Mute,
   output logic                Underrun,
   output logic                DAC_Clk,
   output logic                DAC_Data
);
   logic [CLK_DIV_LOG2-1:0]    r_part;
   logic [OSR_LOG2-1:0]        r_bit;
   logic signed [SAMPLE_W-1:0] r_buffer, r_current, r_target, w_ramp_sat;
   logic signed [SAMPLE_W:0]   r_step, w_diff, w_delta;
   logic signed [SAMPLE_W+1:0] w_ramp;
   logic                       r_full, w_tick, w_boundary, w_xfer;
   // timing strobes, handshake and the next interpolated value
   always_comb begin
      w_tick      = &r_part;
      w_boundary  = w_tick && (&r_bit);
      w_xfer      = Input_Valid && !r_full;
      Input_Ready = !r_full;
      DAC_Clk     = r_part[CLK_DIV_LOG2-1];
      w_diff      = {r_buffer[SAMPLE_W-1], r_buffer} - {r_target[SAMPLE_W-1], r_target};
      w_delta     = w_diff >>> OSR_LOG2;
      w_ramp      = {{2{r_current[SAMPLE_W-1]}}, r_current} + {r_step[SAMPLE_W], r_step};
      w_ramp_sat  = (w_ramp[SAMPLE_W+1:SAMPLE_W-1] == 3'b000 || w_ramp[SAMPLE_W+1:SAMPLE_W-1] == 3'b111) ?
                    w_ramp[SAMPLE_W-1:0] :
                    w_ramp[SAMPLE_W+1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
   end
   // bit-clock divider, bit counter and one-entry input buffer
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_part   <= '0;
         r_bit    <= '0;
         r_buffer <= '0;
         r_full   <= 1'b0;
      end else begin
         r_part <= r_part + 1'b1;
         if (w_tick) r_bit <= r_bit + 1'b1;
         if (w_xfer) r_buffer <= Input;
         r_full <= w_xfer || (r_full && !w_boundary);
      end
   end
   // target/step reload at sample boundaries, linear ramp on the other bit ticks
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_current <= '0;
         r_target  <= '0;
         r_step    <= '0;
         Underrun  <= 1'b0;
      end else if (w_boundary) begin
         r_current <= r_target;
         r_target  <= r_full ? r_buffer : r_target;
         r_step    <= r_full ? w_delta : '0;
         Underrun  <= Underrun || !r_full;
      end else if (w_tick) begin
         r_current <= w_ramp_sat;
      end
   end
   sigma_delta_dac_modulator u_mod (
      .Clk   (Clk),
      .Reset (Reset),
      .Tick  (w_tick),
      .X     (r_current),
      .Mute  (Mute),
      .Bit   (DAC_Data)
   );
endmodule

// File: doc/sigma_delta_dac.md
SIGMA_DELTA_DAC -- requirements
Module: sigma_delta_dac

Interface
REQ-001 Parameter CLK_DIV_LOG2, default 3: bit period is 2^CLK_DIV_LOG2 Clk cycles.
REQ-002 Parameter OSR_LOG2, default 6: bits per sample is 2^OSR_LOG2, so a sample period is 512 Clk at defaults.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 Port Clk, input, 1 bit: sole clock, all logic on the rising edge, max 8 MHz.
REQ-005 Port Reset, input, 1 bit: synchronous, active-high.
REQ-006 Port Input, input, 24 bits: signed two's-complement sample.
REQ-007 Port Input_Valid, input, 1 bit: Input holds a sample.
REQ-008 Port Input_Ready, output, 1 bit: the one-entry buffer is empty.
REQ-009 Port Mute, input, 1 bit: forces the modulator input to zero.
REQ-010 Port Underrun, output, 1 bit: sticky flag, a sample boundary occurred with the buffer empty.
REQ-011 Port DAC_Clk, output, 1 bit: bit clock.
REQ-012 Port DAC_Data, output, 1 bit: 1-bit modulator bitstream.

Function
REQ-013 A free-running CLK_DIV_LOG2-bit Part counter SHALL drive DAC_Clk, which equals the Part MSB (Clk/8 at defaults).
REQ-014 A bit tick SHALL occur in the cycle where Part is all-ones; DAC_Data changes only on the following edge, so it is stable at every DAC_Clk rising edge.
REQ-015 An OSR_LOG2-bit Bit counter SHALL increment on each bit tick; a sample boundary is a bit tick with Bit all-ones.
REQ-016 Input handshake: a transfer occurs when Input_Valid and Input_Ready are both high at a rising edge; Input is copied to Buffer and Full is set.
REQ-017 Input_Ready SHALL be combinational !Full.
REQ-018 At a sample boundary with Full set at the start of the cycle: Current <= Target, Target <= Buffer, Step <= (Buffer - Target) >>> OSR_LOG2 (25-bit signed, arithmetic shift), and Full is cleared.
REQ-019 At a sample boundary with Full clear: Current <= Target, Step <= 0, Target unchanged, Underrun set.
REQ-020 A transfer in the same cycle as a boundary with Full clear SHALL fill Buffer; that sample is consumed at the next boundary, and the current boundary still counts as an underrun.
REQ-021 On a non-boundary bit tick, Current <= Current + Step, with the 24-bit result saturated to [-2^23, 2^23-1].
REQ-022 Modulator input x = Mute ? 0 : Current, sign-extended; fb = +2^23 if DAC_Data else -2^23.
REQ-023 On each bit tick: I1 <= sat28(I1 + x - fb); I2 <= sat28(I2 + I1_new - fb); DAC_Data <= !I2_new[27]. All values 28-bit signed; sat28 clamps to [-2^27, 2^27-1].
REQ-024 Latency: a sample consumed at boundary N SHALL equal Current exactly at boundary N+1, ramping linearly in between.
REQ-025 Underrun SHALL clear only on Reset.

Reset
REQ-026 While Reset is high, the following SHALL be cleared at the next edge: Part, Bit, Buffer, Full, Current, Target, Step, I1, I2, Underrun, DAC_Data, DAC_Clk.
REQ-027 Output values after reset: DAC_Clk=0, DAC_Data=0, Underrun=0, Input_Ready=1.
REQ-028 Reset asserted mid-sample SHALL discard the buffered sample and restart the counters from zero in the cycle after deassertion.

Structure
REQ-029 Package sigma_delta_dac_pkg SHALL hold the sample width (24), integrator width (28), and feedback magnitude (2^23) constants, plus the sat28 function.
REQ-030 The two-integrator loop (REQ-022, REQ-023) SHALL be a sub-module sigma_delta_dac_modulator with ports Clk, Reset, Tick, X, Mute, and Bit.

Verification
REQ-031 Reset then idle with no samples -> Underrun=1 at the first boundary (Clk 512); DAC_Data density 50% ±1 bit over 64 bits.
REQ-032 Stream a constant 0x400000 (+0.5 FS) every sample period -> ones density 75% ±2% averaged over 16 samples; Underrun stays 0.
REQ-033 Apply 0x7FFFFF then 0x800000 -> no integrator wrap, Current saturates without sign flip, DAC_Data runs of 1s then 0s.
REQ-034 Hold Input_Valid while Full -> Input_Ready=0 until the boundary, then exactly one new transfer; Step equals (new-old)>>>6 (e.g. 0x000000->0x010000 gives Step 0x000400).
REQ-035 Transfer a sample in the exact boundary cycle with Full clear -> Underrun=1, and the sample becomes Target at the following boundary.
REQ-036 Assert Reset at bit 30 of a sample -> all outputs match their reset values next cycle; DAC_Clk toggles again starting 4 Clk after deassertion.
